// File: rtl/alu_pin_driver.sv
// alu_pin_driver
//   Drives a small 4-bit ALU's pins with one request at a time. The request
//   operands are held on the pins for SETTLE_CYCLES+1 cycles with ena high.
//   The result bus is then captured and offered on a valid/ready response port.
//
// Parameters
//   SETTLE_CYCLES  cycles the pins are held before the result is sampled (1..15)
//
// Optional feature
//   ALU_DRV_CHECK_EN  when defined, the captured result is compared against an
//                     internal model of ops 0..3 and rsp_err flags a mismatch.
//                     When undefined, no model logic is built and rsp_err is 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     request handshake, operands req_a, req_b, opcode req_op
//   drv_ui, drv_uio     ALU ui_in = {B, A}, uio_in = {5'b0, op}
//   drv_ena             ALU ena, high only while settling
//   dut_uo              ALU uo_out result bus
//   rsp_valid/ready     response handshake, rsp_data captured result, rsp_err flag
//   txn_count           completed transactions, wraps 255 -> 0
//
// States
//   IDLE   | ready for a request, pins hold last value
//   SETTLE | pins driven with ena high, counter running down
//   RESP   | result captured, waiting for rsp_ready

module alu_pin_driver #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [2:0] req_op,
  output logic [7:0] drv_ui,
  output logic [7:0] drv_uio,
  output logic       drv_ena,
  input  logic [7:0] dut_uo,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] txn_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       capture;

  // Result is sampled on the edge where the settle counter has reached zero.
  assign capture = (state == SETTLE) && (settle_cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      req_ready  <= 1'b1;
      drv_ui     <= 8'h00;
      drv_uio    <= 8'h00;
      drv_ena    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      txn_count  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            drv_ui     <= {req_b, req_a};
            drv_uio    <= {5'b00000, req_op};
            settle_cnt <= SETTLE_LOAD;
            drv_ena    <= 1'b1;
            req_ready  <= 1'b0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            rsp_data  <= dut_uo;
            rsp_valid <= 1'b1;
            drv_ena   <= 1'b0;
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            txn_count <= txn_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          drv_ena   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_DRV_CHECK_EN
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [7:0] model_res;
  logic       mismatch;

  assign op_a = drv_ui[3:0];
  assign op_b = drv_ui[7:4];

  always_comb begin
    model_res = 8'h00;
    case (drv_uio[1:0])
      2'd0: model_res = {3'b000, ({1'b0, op_a} + {1'b0, op_b})};
      2'd1: model_res = {4'h0, op_a} - {4'h0, op_b};
      2'd2: model_res = {4'h0, op_a & op_b};
      2'd3: model_res = {4'h0, op_a | op_b};
      default: model_res = 8'h00;
    endcase
  end

  // Opcodes 4..7 are not modelled and never flag.
  assign mismatch = ~drv_uio[2] && (dut_uo != model_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (capture) begin
      rsp_err <= mismatch;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_err <= 1'b0;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pin_driver.sv
module tb_alu_pin_driver;

  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_a = 4'h0;
  logic [3:0] req_b = 4'h0;
  logic [2:0] req_op = 3'h0;
  logic       rsp_ready = 1'b0;
  logic [7:0] dut_uo = 8'h00;

  logic       req_ready, drv_ena, rsp_valid, rsp_err;
  logic [7:0] drv_ui, drv_uio, rsp_data, txn_count;

  logic       rr1, ena1, rv1, re1, rr15, ena15, rv15, re15;
  logic [7:0] ui1, uio1, rd1, tc1, ui15, uio15, rd15, tc15;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_cnt = 8'h00;

  always #5 clk = ~clk;

  alu_pin_driver #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .drv_ui(drv_ui),
    .drv_uio(drv_uio), .drv_ena(drv_ena), .dut_uo(dut_uo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .txn_count(txn_count));

  alu_pin_driver #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr1),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .drv_ui(ui1),
    .drv_uio(uio1), .drv_ena(ena1), .dut_uo(dut_uo),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1),
    .rsp_err(re1), .txn_count(tc1));

  alu_pin_driver #(.SETTLE_CYCLES(15)) dut_s15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr15),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .drv_ui(ui15),
    .drv_uio(uio15), .drv_ena(ena15), .dut_uo(dut_uo),
    .rsp_valid(rv15), .rsp_ready(rsp_ready), .rsp_data(rd15),
    .rsp_err(re15), .txn_count(tc15));

  // Reference ALU result for the modelled opcodes 0..3.
  function automatic logic [7:0] alu_ref(input int a, input int b, input int op);
    case (op)
      0: return 8'((a + b) & 255);
      1: return 8'((a - b) & 255);
      2: return 8'(a & b);
      3: return 8'(a | b);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic exp_err(input int a, input int b, input int op, input logic [7:0] uo);
`ifdef ALU_DRV_CHECK_EN
    return (op < 4) && (uo != alu_ref(a, b, op));
`else
    return 1'b0;
`endif
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 8'h00;
  endtask

  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic [7:0] uo, input int hold, input bit intrude);
    int lat;
    int ena_n;
    logic e;
    e = exp_err(int'(a), int'(b), int'(op), uo);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_pre: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; dut_uo = uo;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_a = 4'($urandom); req_b = 4'($urandom); req_op = 3'($urandom);
    n_cmp++;
    if (drv_ui !== {b, a} || drv_uio !== {5'b0, op}) begin
      n_err++; $display("FAIL pins: got ui=%h uio=%h want ui=%h uio=%h", drv_ui, drv_uio, {b, a}, {5'b0, op});
    end
    lat = -1; ena_n = 0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) begin @(posedge clk); @(negedge clk); end
      if (drv_ena === 1'b1) ena_n++;
      if (rsp_valid === 1'b1) begin lat = k; break; end
    end
    n_cmp++;
    if (lat != SC + 1) begin
      n_err++; $display("FAIL latency: got %0d want %0d", lat, SC + 1);
      return;
    end
    n_cmp++;
    if (ena_n != SC + 1) begin
      n_err++; $display("FAIL ena_cycles: got %0d want %0d", ena_n, SC + 1);
    end
    n_cmp++;
    if (rsp_data !== uo || rsp_err !== e) begin
      n_err++; $display("FAIL rsp: got data=%h err=%b want data=%h err=%b", rsp_data, rsp_err, uo, e);
    end
    for (int i = 0; i < hold; i++) begin
      if (intrude) begin
        req_valid = 1'b1; req_a = ~a; req_b = ~b; req_op = ~op;
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== uo || rsp_err !== e || req_ready !== 1'b0 ||
          drv_ui !== {b, a} || drv_ena !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: got v=%b d=%h e=%b rdy=%b ui=%h ena=%b want v=1 d=%h e=%b rdy=0 ui=%h ena=0",
                 i, rsp_valid, rsp_data, rsp_err, req_ready, drv_ui, drv_ena, uo, e, {b, a});
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || txn_count !== exp_cnt || drv_ui !== {b, a} ||
        drv_uio !== {5'b0, op}) begin
      n_err++;
      $display("FAIL handshake: got v=%b rdy=%b cnt=%h ui=%h uio=%h want v=0 rdy=1 cnt=%h ui=%h uio=%h",
               rsp_valid, req_ready, txn_count, drv_ui, drv_uio, exp_cnt, {b, a}, {5'b0, op});
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_cmp++;
    if (req_ready !== 1'b1 || drv_ui !== 8'h00 || drv_uio !== 8'h00 || drv_ena !== 1'b0 ||
        rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_err !== 1'b0 || txn_count !== 8'h00) begin
      n_err++;
      $display("FAIL %s: got rdy=%b ui=%h uio=%h ena=%b v=%b d=%h e=%b cnt=%h want 1 00 00 0 0 00 0 00",
               tag, req_ready, drv_ui, drv_uio, drv_ena, rsp_valid, rsp_data, rsp_err, txn_count);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_reset_vals("reset_hold");
    apply_reset();
    check_reset_vals("reset_release");
  endtask

  task automatic test_directed();
    run_txn(4'd3, 4'd5, 3'd0, 8'h08, 0, 1'b0);
    run_txn(4'd9, 4'd4, 3'd3, 8'h0D, 10, 1'b1);
  endtask

  task automatic test_check();
    run_txn(4'd2, 4'd7, 3'd1, 8'hFB, 2, 1'b0);
    run_txn(4'd2, 4'd7, 3'd1, 8'h05, 2, 1'b0);
    run_txn(4'd2, 4'd7, 3'd5, 8'h05, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] a, b;
    logic [2:0] op;
    logic [7:0] uo;
    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
      uo = ($urandom_range(0, 1) == 1) ? alu_ref(int'(a), int'(b), int'(op)) : 8'($urandom);
      run_txn(a, b, op, uo, $urandom_range(0, 4), 1'($urandom));
    end
  endtask

  task automatic test_wrap();
    logic [3:0] a, b;
    logic [2:0] op;
    apply_reset();
    for (int n = 0; n < 256; n++) begin
      a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
      run_txn(a, b, op, alu_ref(int'(a), int'(b), int'(op)), 0, 1'b0);
    end
    n_cmp++;
    if (txn_count !== 8'h00) begin
      n_err++; $display("FAIL wrap: got %h want 00", txn_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    req_valid = 1'b1; req_a = 4'd6; req_b = 4'd1; req_op = 3'd2; dut_uo = 8'h00;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (drv_ena !== 1'b1) begin
      n_err++; $display("FAIL mid_settle_ena: got %b want 1", drv_ena);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset_mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0 || txn_count !== 8'h00 || drv_ena !== 1'b0) begin
        n_err++; $display("FAIL reset_mid_after[%0d]: got v=%b cnt=%h ena=%b want 0 00 0", i, rsp_valid, txn_count, drv_ena);
      end
    end
    run_txn(4'd1, 4'd1, 3'd0, 8'h02, 0, 1'b0);
  endtask

  task automatic test_settle_param();
    int l2, l1, l15;
    apply_reset();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_a = 4'd3; req_b = 4'd5; req_op = 3'd0; dut_uo = 8'h08;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    l2 = -1; l1 = -1; l15 = -1;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) begin @(posedge clk); @(negedge clk); end
      if (rsp_valid === 1'b1 && l2 < 0) l2 = k;
      if (rv1 === 1'b1 && l1 < 0) l1 = k;
      if (rv15 === 1'b1 && l15 < 0) l15 = k;
    end
    rsp_ready = 1'b0;
    n_cmp++;
    if (l1 != 2) begin n_err++; $display("FAIL lat_s1: got %0d want 2", l1); end
    n_cmp++;
    if (l2 != 3) begin n_err++; $display("FAIL lat_s2: got %0d want 3", l2); end
    n_cmp++;
    if (l15 != 16) begin n_err++; $display("FAIL lat_s15: got %0d want 16", l15); end
    n_cmp++;
    if (tc1 !== 8'd1 || tc15 !== 8'd1 || rd15 !== 8'h08) begin
      n_err++; $display("FAIL param_done: got tc1=%h tc15=%h rd15=%h want 01 01 08", tc1, tc15, rd15);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_check();
    test_random();
    test_reset_mid();
    test_settle_param();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_pin_driver.md
ALU_PIN_DRIVER -- requirements
Module: alu_pin_driver

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, sets the cycles DUT pins are held before the result is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  driver can accept a request.
REQ-006 req_a  input  4  operand A.
REQ-007 req_b  input  4  operand B.
REQ-008 req_op  input  3  ALU opcode.
REQ-009 drv_ui  output  8  drives ALU ui_in = {operand B, operand A}.
REQ-010 drv_uio  output  8  drives ALU uio_in = {5'b0, opcode}.
REQ-011 drv_ena  output  1  drives ALU ena.
REQ-012 dut_uo  input  8  ALU uo_out result bus.
REQ-013 rsp_valid  output  1  captured result available.
REQ-014 rsp_ready  input  1  consumer accepts result.
REQ-015 rsp_data  output  8  captured dut_uo value.
REQ-016 rsp_err  output  1  result mismatch flag, valid with rsp_valid.
REQ-017 txn_count  output  8  completed transaction count.

Function
REQ-018 FSM states SHALL be IDLE, SETTLE, RESP; req_ready = 1 only in IDLE.
REQ-019 Accept = req_valid & req_ready at an edge: register drv_ui, drv_uio, load settle counter with SETTLE_CYCLES, enter SETTLE.
REQ-020 drv_ena SHALL be 1 exactly while in SETTLE, 0 in IDLE and RESP.
REQ-021 In SETTLE counter decrements each edge; at the edge where counter is 0, dut_uo is registered into rsp_data and FSM enters RESP.
REQ-022 rsp_valid SHALL rise exactly SETTLE_CYCLES+1 edges after the accept edge (default: 3).
REQ-023 In RESP, rsp_valid, rsp_data, rsp_err SHALL hold stable until rsp_valid & rsp_ready; on that edge go to IDLE and increment txn_count.
REQ-024 txn_count SHALL wrap 255 -> 0 without flag.
REQ-025 drv_ui/drv_uio SHALL hold last driven value in IDLE and RESP.
REQ-026 A request presented during SETTLE/RESP SHALL not be accepted; earliest acceptance is the first IDLE cycle after response handshake (no back-to-back in the same edge).
REQ-027 req_valid deasserting after acceptance SHALL not affect the transaction in progress.

Reset
REQ-028 While rst_n = 0: state IDLE, req_ready 1, drv_ui 0, drv_uio 0, drv_ena 0, rsp_valid 0, rsp_data 0, rsp_err 0, txn_count 0, counter 0.
REQ-029 Reset mid-transaction SHALL abort it with no response and no txn_count increment.
REQ-030 Deassertion SHALL be synchronous-safe: first accept possible at the first edge with rst_n = 1.

Configuration
REQ-031 Macro ALU_DRV_CHECK_EN defined: captured value compared with internal model; rsp_err = 1 on mismatch for opcodes 0..3; 0 for opcodes 4..7.
REQ-032 Model: op0 ADD = zero-extended 5-bit A+B; op1 SUB = 8-bit two's complement A-B; op2 AND and op3 OR zero-extended to 8 bits.
REQ-033 Macro undefined: no model logic synthesized, rsp_err tied 0.

Verification
REQ-034 Reset: rst_n low mid-SETTLE -> all outputs at reset values immediately, no rsp_valid after release.
REQ-035 A=3, B=5, op=0, dut_uo returns 0x08, SETTLE_CYCLES=2 -> drv_ui=0x53, drv_uio=0x00, drv_ena high 3 cycles, rsp_valid at edge 3, rsp_data=0x08, rsp_err=0.
REQ-036 With ALU_DRV_CHECK_EN: A=2, B=7, op=1, dut_uo=0xFB -> rsp_err=0; dut_uo=0x05 -> rsp_err=1.
REQ-037 Backpressure: rsp_ready low 10 cycles -> rsp_valid/rsp_data stable, req_ready 0, second req_valid ignored until handshake.
REQ-038 256 completed transactions -> txn_count reads 0x00.
REQ-039 SETTLE_CYCLES=1 and 15 -> rsp_valid at edge 2 and 16 respectively.
